multiport_memory: RTL

MULTIPORT_MEMORY -- requirements
Module: multiport_memory

---
 rtl/multiport_memory.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/multiport_memory.sv
// Multi-port word memory with byte strobes, self-clearing after reset and 1- or 2-cycle reads.
// Define MEM_WR_FORWARD_EN for write-first same-cycle reads; default build is read-first.
module multiport_memory #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MEM_SIZE        = 1024,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 1,
    parameter int READ_LATENCY    = 1
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    write_data,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]    write_addr,
    input  logic [NUM_WRITE_PORTS-1:0]                    write_enable,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH/8-1:0]  write_strobe,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]     read_addr,
    input  logic [NUM_READ_PORTS-1:0]                     read_enable,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]     read_data,
    output logic [NUM_READ_PORTS-1:0]                     read_valid,
    output logic                                          ready
);

    localparam int                IDX_W   = $clog2(MEM_SIZE);
    localparam int                NBYTES  = DATA_WIDTH / 8;
    localparam logic [IDX_W-1:0]  LP_LAST = IDX_W'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0] LP_LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                                    r_state;
    logic [IDX_W-1:0]                          r_clear_ptr;
    logic                                      r_ready;
    logic [DATA_WIDTH-1:0]                     r_mem [MEM_SIZE];
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] r_read_data;
    logic [NUM_READ_PORTS-1:0]                 r_read_valid;

    logic [NUM_READ_PORTS-1:0]                 w_vld_p0;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] w_rd_word_p0;
    logic [NUM_READ_PORTS-1:0]                 w_stage_vld;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] w_stage_data;

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < LP_LIM);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_CLEAR;
            r_clear_ptr <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clear_ptr <= r_clear_ptr + IDX_W'(1);
                    if (r_clear_ptr == LP_LAST) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;

    // Later write ports are applied after earlier ones so the highest index wins per byte.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clear_ptr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (write_enable[p] && f_in_range(write_addr[p]) && write_strobe[p][b]) begin
                        r_mem[write_addr[p][IDX_W-1:0]][b*8 +: 8] <= write_data[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Stage p0: array lookup, optional same-cycle write merge.
    assign w_vld_p0 = read_enable & {NUM_READ_PORTS{r_state == ST_READY}};

    always_comb begin
        w_rd_word_p0 = '0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            if (f_in_range(read_addr[r])) begin
                w_rd_word_p0[r] = r_mem[read_addr[r][IDX_W-1:0]];
`ifdef MEM_WR_FORWARD_EN
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (write_enable[p] && (write_addr[p] == read_addr[r]) && write_strobe[p][b]) begin
                            w_rd_word_p0[r][b*8 +: 8] = write_data[p][b*8 +: 8];
                        end
                    end
                end
`endif
            end
        end
    end

    // Stage p1: extra register slice only for the two-cycle configuration.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [NUM_READ_PORTS-1:0]                 r_vld_p1;
            logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] r_data_p1;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld_p1 <= '0;
                end else begin
                    r_vld_p1 <= w_vld_p0;
                end
            end

            always_ff @(posedge clk) begin
                for (int r = 0; r < NUM_READ_PORTS; r++) begin
                    if (w_vld_p0[r]) begin
                        r_data_p1[r] <= w_rd_word_p0[r];
                    end
                end
            end

            assign w_stage_vld  = r_vld_p1;
            assign w_stage_data = r_data_p1;
        end else begin : g_lat1
            assign w_stage_vld  = w_vld_p0;
            assign w_stage_data = w_rd_word_p0;
        end
    endgenerate

    // Output stage: data holds whenever no read completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read_valid <= '0;
            r_read_data  <= '0;
        end else begin
            r_read_valid <= w_stage_vld;
            for (int r = 0; r < NUM_READ_PORTS; r++) begin
                if (w_stage_vld[r]) begin
                    r_read_data[r] <= w_stage_data[r];
                end
            end
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;

endmodule
